// File: rtl/framebuffer_scanout_if.sv
// Avalon-MM read port and Avalon-ST pixel port of the framebuffer scanout engine.
// master = the scanout engine; slave = the OCRAM plus the display sink.
interface framebuffer_scanout_if;
   logic [31:0] m_address;
   logic        m_read;
   logic        m_waitrequest;
   logic [15:0] m_readdata;
   logic        m_readdatavalid;
   logic [15:0] px_data;
   logic        px_valid;
   logic        px_ready;
   logic        px_sop;
   logic        px_eop;

   modport master (
      output m_address, m_read, px_data, px_valid, px_sop, px_eop,
      input  m_waitrequest, m_readdata, m_readdatavalid, px_ready
   );

   modport slave (
      input  m_address, m_read, px_data, px_valid, px_sop, px_eop,
      output m_waitrequest, m_readdata, m_readdatavalid, px_ready
   );
endinterface

// File: rtl/framebuffer_scanout.sv
// Walks one frame of 16-bit pixels in OCRAM and streams it out through a pixel FIFO.
// Reads are credit-limited, so every returned word always has a free FIFO slot.
module framebuffer_scanout #(
   parameter int unsigned H_RES      = 320,
   parameter int unsigned V_RES      = 240,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [31:0]           fb_base,
   output logic                  busy,
   output logic                  done,
   framebuffer_scanout_if.master bus
);
   localparam int unsigned    AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [7:0]     ROW_LAST = 8'(V_RES - 1);
   localparam logic [8:0]     COL_LAST = 9'(H_RES - 1);
   localparam logic [AW+1:0]  DEPTH_W  = FIFO_DEPTH[AW+1:0];

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t        state;
   logic [31:0]   base;
   logic [31:0]   m_address_q;
   logic          m_read_q;
   logic [7:0]    row, nr, orow;
   logic [8:0]    col, nc, ocol;
   logic [AW:0]   in_flight, in_flight_nxt, count, count_nxt;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [15:0]   mem [FIFO_DEPTH];
   logic          accept, push, pop, credit_ok, last_req, last_popped, px_valid_i;

   assign px_valid_i    = (count != '0);
   assign bus.m_address = m_address_q;
   assign bus.m_read    = m_read_q;
   assign bus.px_valid  = px_valid_i;
   assign bus.px_data   = px_valid_i ? mem[rd_ptr] : '0;
   assign bus.px_sop    = px_valid_i && (orow == '0) && (ocol == '0);
   assign bus.px_eop    = px_valid_i && (orow == ROW_LAST) && (ocol == COL_LAST);

   // Credit is judged on post-update counts so the next issued read already has its slot.
   always_comb begin
      accept        = m_read_q && !bus.m_waitrequest;
      push          = bus.m_readdatavalid && (state != IDLE);
      pop           = px_valid_i && bus.px_ready;
      in_flight_nxt = in_flight + {{AW{1'b0}}, accept} - {{AW{1'b0}}, push};
      count_nxt     = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      credit_ok     = ({1'b0, count_nxt} + {1'b0, in_flight_nxt}) < DEPTH_W;
      last_req      = (row == ROW_LAST) && (col == COL_LAST);
      nc            = col + 9'd1;
      nr            = row;
      if (col == COL_LAST) begin
         nc = '0;
         nr = row + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.m_readdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         base        <= '0;
         row         <= '0;
         col         <= '0;
         m_address_q <= '0;
         m_read_q    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         in_flight   <= '0;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         orow        <= '0;
         ocol        <= '0;
         last_popped <= 1'b0;
      end else begin
         done      <= 1'b0;
         in_flight <= in_flight_nxt;
         count     <= count_nxt;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;

         // sop/eop track what the sink has taken, independent of the read side
         if (state == IDLE && start) begin
            orow        <= '0;
            ocol        <= '0;
            last_popped <= 1'b0;
         end else if (pop) begin
            if (ocol == COL_LAST) begin
               ocol <= '0;
               orow <= orow + 8'd1;
            end else begin
               ocol <= ocol + 9'd1;
            end
            if (orow == ROW_LAST && ocol == COL_LAST) last_popped <= 1'b1;
         end

         case (state)
            IDLE: if (start) begin
               base        <= fb_base;
               row         <= '0;
               col         <= '0;
               m_address_q <= fb_base;
               m_read_q    <= 1'b1;
               busy        <= 1'b1;
               state       <= FETCH;
            end
            FETCH: begin
               if (accept) begin
                  if (last_req) begin
                     m_read_q <= 1'b0;
                     state    <= DRAIN;
                  end else begin
                     row         <= nr;
                     col         <= nc;
                     m_address_q <= base + {14'd0, nr, nc, 1'b0};
                     m_read_q    <= credit_ok;
                  end
               end else if (!m_read_q) begin
                  m_read_q <= credit_ok;
               end
            end
            DRAIN: if (in_flight == '0 && count == '0 && last_popped) begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && count[AW]));
endmodule

// File: tb/tb_framebuffer_scanout.sv
// Directed bench for framebuffer_scanout on a 4x2 frame with a 4-entry FIFO,
// backed by a mock OCRAM whose word at byte address a holds a[16:1].
module tb_framebuffer_scanout;
   localparam int NPX = 8;

   typedef struct {
      logic [15:0] data;
      int unsigned due;
   } rsp_t;

   typedef struct {
      logic [15:0] d;
      logic        sop;
      logic        eop;
   } px_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start;
   logic [31:0] fb_base;
   logic        busy;
   logic        done;

   framebuffer_scanout_if bus();

   framebuffer_scanout #(
      .H_RES(4),
      .V_RES(2),
      .FIFO_DEPTH(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .fb_base(fb_base),
      .busy(busy),
      .done(done),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   int unsigned cyc = 0;
   int unsigned lat;
   int unsigned lat_fixed = 1;
   int          lmode = 0;
   int          wmode = 0;
   int          rmode = 0;
   int          clear_seq = 0;
   int          clear_seen = 0;
   int          done_cnt = 0;
   int          stall_left = 0;
   int          stall_seen = 0;
   int          stall_bad = 0;
   bit          stall_used = 1'b0;
   logic [31:0] stall_addr;
   rsp_t        mq[$];
   logic [31:0] addr_log[$];
   px_t         rx[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Mock OCRAM, waitrequest generator and pixel sink, all acting on the falling edge.
   always @(negedge clk) begin
      cyc++;
      if (clear_seq != clear_seen) begin
         clear_seen = clear_seq;
         addr_log.delete();
         rx.delete();
         stall_seen = 0;
         stall_bad  = 0;
         stall_used = 1'b0;
      end
      if (reset) begin
         mq.delete();
         bus.m_readdatavalid = 1'b0;
         bus.m_readdata      = '0;
         bus.m_waitrequest   = 1'b0;
         stall_left          = 0;
      end else begin
         bus.m_readdatavalid = 1'b0;
         bus.m_readdata      = '0;
         if (mq.size() != 0 && mq[0].due <= cyc) begin
            bus.m_readdatavalid = 1'b1;
            bus.m_readdata      = mq[0].data;
            void'(mq.pop_front());
         end
         bus.m_waitrequest = 1'b0;
         if (wmode == 1) begin
            bus.m_waitrequest = ($urandom_range(0, 2) == 0);
         end else if (wmode == 2) begin
            if (bus.m_read && addr_log.size() == 2 && !stall_used) begin
               stall_used = 1'b1;
               stall_left = 5;
               stall_addr = bus.m_address;
            end
            if (stall_left != 0) begin
               bus.m_waitrequest = 1'b1;
               stall_left--;
               stall_seen++;
               if (!bus.m_read || bus.m_address !== stall_addr) stall_bad++;
            end
         end
         if (bus.m_read && !bus.m_waitrequest) begin
            lat = (lmode != 0) ? $urandom_range(1, 8) : lat_fixed;
            addr_log.push_back(bus.m_address);
            mq.push_back('{data: bus.m_address[16:1], due: cyc + lat});
         end
      end
      bus.px_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      if (bus.px_valid && bus.px_ready)
         rx.push_back('{d: bus.px_data, sop: bus.px_sop, eop: bus.px_eop});
      if (done) done_cnt++;
   end

   task automatic start_frame(input logic [31:0] base);
      clear_seq++;
      @(negedge clk);
      fb_base = base;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk);
         if (done_cnt >= target) break;
      end
      if (done_cnt < target) check("done_timeout", done_cnt, target);
      repeat (5) @(posedge clk);
   endtask

   task automatic check_frame(input string name, input logic [31:0] base);
      logic [31:0] a;
      check({name, "_px_count"}, rx.size(), NPX);
      check({name, "_rd_count"}, addr_log.size(), NPX);
      for (int k = 0; k < NPX; k++) begin
         a = base + 32'((k / 4) << 10) + 32'((k % 4) << 1);
         if (k < addr_log.size()) check($sformatf("%s_addr%0d", name, k), addr_log[k], a);
         if (k < rx.size()) begin
            check($sformatf("%s_data%0d", name, k), rx[k].d, {16'd0, a[16:1]});
            check($sformatf("%s_sop%0d", name, k), rx[k].sop, (k == 0));
            check($sformatf("%s_eop%0d", name, k), rx[k].eop, (k == NPX - 1));
         end
      end
   endtask

   initial begin
      int d0;
      start   = 1'b0;
      fb_base = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_m_read", bus.m_read, 0);
      check("rst_m_address", bus.m_address, 0);
      check("rst_px_valid", bus.px_valid, 0);
      check("rst_px_data", bus.px_data, 0);
      check("rst_px_sop", bus.px_sop, 0);
      check("rst_px_eop", bus.px_eop, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // basic frame, 1-cycle latency
      d0 = done_cnt;
      start_frame(32'h0800_0000);
      #1;
      check("t1_first_read", bus.m_read, 1);
      check("t1_first_addr", bus.m_address, 32'h0800_0000);
      check("t1_busy", busy, 1);
      check("t1_no_early_px", bus.px_valid, 0);
      wait_done(d0 + 1);
      check("t1_done_pulses", done_cnt, d0 + 1);
      check("t1_busy_after", busy, 0);
      check_frame("t1", 32'h0800_0000);

      // sink blocked: credit stops reads at FIFO depth
      rmode = 1;
      d0 = done_cnt;
      start_frame(32'h0000_2000);
      repeat (30) @(negedge clk);
      #1;
      check("t2_reads_issued", addr_log.size(), 4);
      check("t2_m_read_low", bus.m_read, 0);
      check("t2_px_valid", bus.px_valid, 1);
      check("t2_px_sop", bus.px_sop, 1);
      check("t2_px_data", bus.px_data, 16'h1000);
      rmode = 0;
      wait_done(d0 + 1);
      check("t2_done_pulses", done_cnt, d0 + 1);
      check_frame("t2", 32'h0000_2000);

      // 5-cycle waitrequest on the 3rd read
      wmode = 2;
      d0 = done_cnt;
      start_frame(32'h0000_4000);
      wait_done(d0 + 1);
      wmode = 0;
      check("t3_stall_cycles", stall_seen, 5);
      check("t3_stall_unstable", stall_bad, 0);
      check("t3_done_pulses", done_cnt, d0 + 1);
      check_frame("t3", 32'h0000_4000);

      // start while busy is ignored; start after done repeats the frame
      d0 = done_cnt;
      start_frame(32'h0010_0000);
      repeat (3) @(negedge clk);
      fb_base = 32'h0020_0000;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      wait_done(d0 + 1);
      repeat (20) @(posedge clk);
      check("t4_single_done", done_cnt, d0 + 1);
      check("t4_busy_idle", busy, 0);
      check_frame("t4a", 32'h0010_0000);
      start_frame(32'h0010_0000);
      wait_done(d0 + 2);
      check("t4_second_done", done_cnt, d0 + 2);
      check_frame("t4b", 32'h0010_0000);

      // reset with three reads in flight
      lat_fixed = 8;
      d0 = done_cnt;
      start_frame(32'h0000_6000);
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         if (addr_log.size() >= 3) break;
      end
      check("t5_reads_before_reset", addr_log.size(), 3);
      reset = 1'b1;
      #1;
      check("t5_m_read", bus.m_read, 0);
      check("t5_m_address", bus.m_address, 0);
      check("t5_busy", busy, 0);
      check("t5_px_valid", bus.px_valid, 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      lat_fixed = 1;
      repeat (20) @(posedge clk);
      check("t5_no_done", done_cnt, d0);
      check("t5_busy_after", busy, 0);
      start_frame(32'h0000_6000);
      wait_done(d0 + 1);
      check("t5_done_pulses", done_cnt, d0 + 1);
      check_frame("t5", 32'h0000_6000);

      // random latency, waitrequest and px_ready against the mem[i]=i pattern
      lmode = 1;
      wmode = 1;
      rmode = 2;
      for (int f = 0; f < 3; f++) begin
         d0 = done_cnt;
         start_frame(32'h0000_0000);
         wait_done(d0 + 1);
         check($sformatf("t6_done%0d", f), done_cnt, d0 + 1);
         check_frame($sformatf("t6f%0d", f), 32'h0000_0000);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
